// File: rtl/launch_queue.sv
`default_nettype none
// ============================================================================
// Module   : launch_queue
// Brief    : Dual-issue in-order circular launch queue between decode and
//            launch select. Optional perf counters: LAUNCH_QUEUE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module launch_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               push_valid,
    input  logic [PC_W-1:0]          push0_pc,
    input  logic [PC_W-1:0]          push0_npc,
    input  logic [DC_W-1:0]          push0_dc,
    input  logic [PC_W-1:0]          push1_pc,
    input  logic [PC_W-1:0]          push1_npc,
    input  logic [DC_W-1:0]          push1_dc,
    output logic                     push_ready,
    output logic [PC_W-1:0]          in1_pc,
    output logic [PC_W-1:0]          in1_npc,
    output logic [DC_W-1:0]          in1_decodeout,
    output logic                     receive_flag1,
    output logic [PC_W-1:0]          in2_pc,
    output logic [PC_W-1:0]          in2_npc,
    output logic [DC_W-1:0]          in2_decodeout,
    output logic                     receive_flag2,
    input  logic [3:0]               launch_flag,
    output logic [$clog2(DEPTH):0]   count
`ifdef LAUNCH_QUEUE_PERF_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              dual_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * PC_W + DC_W;
    localparam logic [CW-1:0] c_push_limit = CW'(DEPTH - 2);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_wr0;
    logic          w_wr1;
    logic          w_pop1;
    logic          w_pop2;
    logic [1:0]    w_push_num;
    logic [1:0]    w_pop_num;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;
    logic [EW-1:0] w_ent1;
    logic [EW-1:0] w_ent2;

    // Space check uses registered occupancy only, so pops never free room early.
    assign push_ready = (r_count <= c_push_limit);
    assign w_wr0      = push_ready & (push_valid != 2'b00);
    assign w_wr1      = push_ready & (push_valid == 2'b11);
    assign w_push_num = {1'b0, w_wr0} + {1'b0, w_wr1};

    assign receive_flag1 = (r_count != '0);
    assign receive_flag2 = (r_count >= CW'(2));
    assign w_pop1        = receive_flag1 & (launch_flag[3] | launch_flag[2]);
    assign w_pop2        = w_pop1 & receive_flag2 & (launch_flag[1] | launch_flag[0]);
    assign w_pop_num     = {1'b0, w_pop1} + {1'b0, w_pop2};

    assign w_head1 = r_head + AW'(1);
    assign w_tail1 = r_tail + AW'(1);
    assign w_ent1  = r_mem[r_head];
    assign w_ent2  = r_mem[w_head1];

    assign {in1_pc, in1_npc, in1_decodeout} = w_ent1;
    assign {in2_pc, in2_npc, in2_decodeout} = w_ent2;
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (w_wr0) r_mem[r_tail]  <= {push0_pc, push0_npc, push0_dc};
        if (w_wr1) r_mem[w_tail1] <= {push1_pc, push1_npc, push1_dc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_num);
            r_tail  <= r_tail + AW'(w_push_num);
            r_count <= r_count + CW'(w_push_num) - CW'(w_pop_num);
        end
    end

`ifdef LAUNCH_QUEUE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_dual_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_dual_cnt  <= '0;
        end else if (!flush) begin
            if (receive_flag1 && !w_pop1) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_pop2)                   r_dual_cnt  <= r_dual_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign dual_cnt  = r_dual_cnt;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_launch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_launch_queue
// Brief    : Scoreboard-based self-checking bench for launch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_launch_queue;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int DC_W  = 64;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] npc;
        logic [DC_W-1:0] dc;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      push_valid = 2'b00;
    logic [PC_W-1:0] push0_pc = '0, push0_npc = '0, push1_pc = '0, push1_npc = '0;
    logic [DC_W-1:0] push0_dc = '0, push1_dc = '0;
    logic            push_ready;
    logic [PC_W-1:0] in1_pc, in1_npc, in2_pc, in2_npc;
    logic [DC_W-1:0] in1_decodeout, in2_decodeout;
    logic            receive_flag1, receive_flag2;
    logic [3:0]      launch_flag = 4'b0000;
    logic [3:0]      count;
`ifdef LAUNCH_QUEUE_PERF_EN
    logic [31:0]     stall_cnt, dual_cnt;
`endif

    entry_t          sb[$];
    logic [PC_W-1:0] next_pc = 32'h0;
    int              checks = 0;
    int              passed = 0;
    int unsigned     m_stall = 0;
    int unsigned     m_dual  = 0;

    launch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .DC_W(DC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid),
        .push0_pc(push0_pc), .push0_npc(push0_npc), .push0_dc(push0_dc),
        .push1_pc(push1_pc), .push1_npc(push1_npc), .push1_dc(push1_dc),
        .push_ready(push_ready),
        .in1_pc(in1_pc), .in1_npc(in1_npc), .in1_decodeout(in1_decodeout),
        .receive_flag1(receive_flag1),
        .in2_pc(in2_pc), .in2_npc(in2_npc), .in2_decodeout(in2_decodeout),
        .receive_flag2(receive_flag2),
        .launch_flag(launch_flag), .count(count)
`ifdef LAUNCH_QUEUE_PERF_EN
        , .stall_cnt(stall_cnt), .dual_cnt(dual_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [PC_W-1:0] p);
        entry_t e;
        e.pc  = p;
        e.npc = p + 32'd4;
        e.dc  = {p ^ 32'hA5A5_A5A5, ~p};
        return e;
    endfunction

    // Drives one cycle of stimulus, advances the reference model at the edge,
    // and returns 1 ns after the edge with inputs idled.
    task automatic step(input logic [1:0] pv, input logic [3:0] lf, input logic fl);
        entry_t e0, e1;
        bit acc, p1, p2;
        e0 = mk(next_pc);
        e1 = mk(next_pc + 32'd4);
        push_valid = pv; launch_flag = lf; flush = fl;
        push0_pc = e0.pc; push0_npc = e0.npc; push0_dc = e0.dc;
        push1_pc = e1.pc; push1_npc = e1.npc; push1_dc = e1.dc;
        acc = (sb.size() <= DEPTH - 2);
        p1  = (sb.size() >= 1) && (lf[3] || lf[2]);
        p2  = p1 && (sb.size() >= 2) && (lf[1] || lf[0]);
        @(posedge clk);
        if (!fl) begin
            if (sb.size() >= 1 && !p1) m_stall++;
            if (p2) m_dual++;
        end
        if (fl) sb.delete();
        else begin
            if (p1) void'(sb.pop_front());
            if (p2) void'(sb.pop_front());
            if (acc && pv != 2'b00) begin sb.push_back(e0); next_pc += 32'd4; end
            if (acc && pv == 2'b11) begin sb.push_back(e1); next_pc += 32'd4; end
        end
        #1;
        push_valid = 2'b00; launch_flag = 4'b0000; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_stall = 0;
        m_dual  = 0;
    endtask

    task automatic test_reset();
        push_valid = 2'b11; flush = 1'b1; launch_flag = 4'b1111;
        do_reset();
        push_valid = 2'b00; flush = 1'b0; launch_flag = 4'b0000;
        checks++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
        checks++; if (receive_flag1 !== 1'b0 || receive_flag2 !== 1'b0)
            $display("FAIL reset_flags got=%b%b exp=00", receive_flag1, receive_flag2); else passed++;
        checks++; if (push_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", push_ready); else passed++;
    endtask

    task automatic test_basic_push();
        next_pc = 32'h100;
        push_valid = 2'b11; push0_pc = 32'h100;
        #1;
        checks++; if (receive_flag1 !== 1'b0) $display("FAIL no_bypass flag1 got=%b exp=0", receive_flag1); else passed++;
        step(2'b11, 4'b0000, 1'b0);
        checks++; if (receive_flag1 !== 1'b1 || receive_flag2 !== 1'b1)
            $display("FAIL basic_flags got=%b%b exp=11", receive_flag1, receive_flag2); else passed++;
        checks++; if (in1_pc !== 32'h100 || in2_pc !== 32'h104)
            $display("FAIL basic_pc got=%h/%h exp=100/104", in1_pc, in2_pc); else passed++;
        checks++; if (count !== 4'd2) $display("FAIL basic_count got=%0d exp=2", count); else passed++;
        checks++; if (in1_npc !== sb[0].npc || in1_decodeout !== sb[0].dc || in2_decodeout !== sb[1].dc)
            $display("FAIL basic_payload got=%h/%h exp=%h/%h", in1_npc, in1_decodeout, sb[0].npc, sb[0].dc); else passed++;
    endtask

    task automatic test_full();
        step(2'b11, 4'b0000, 1'b0);
        step(2'b11, 4'b0000, 1'b0);
        checks++; if (count !== 4'd6 || push_ready !== 1'b1)
            $display("FAIL full_at6 count=%0d ready=%b exp=6/1", count, push_ready); else passed++;
        step(2'b11, 4'b0000, 1'b0);
        checks++; if (count !== 4'd8 || push_ready !== 1'b0)
            $display("FAIL full_at8 count=%0d ready=%b exp=8/0", count, push_ready); else passed++;
        step(2'b11, 4'b0000, 1'b0);
        checks++; if (count !== 4'd8 || in1_pc !== 32'h100)
            $display("FAIL full_drop count=%0d pc=%h exp=8/100", count, in1_pc); else passed++;
        step(2'b00, 4'b1000, 1'b0);
        checks++; if (count !== 4'd7 || push_ready !== 1'b0)
            $display("FAIL full_at7 count=%0d ready=%b exp=7/0", count, push_ready); else passed++;
        step(2'b11, 4'b0000, 1'b0);
        checks++; if (count !== 4'd7 || in1_pc !== sb[0].pc)
            $display("FAIL full_drop7 count=%0d pc=%h exp=7/%h", count, in1_pc, sb[0].pc); else passed++;
    endtask

    task automatic test_inorder();
        logic [PC_W-1:0] third;
        step(2'b00, 4'b1001, 1'b0);
        step(2'b00, 4'b0110, 1'b0);
        checks++; if (count !== 4'd3) $display("FAIL inorder_count3 got=%0d exp=3", count); else passed++;
        third = sb[2].pc;
        step(2'b00, 4'b0010, 1'b0);
        checks++; if (count !== 4'd3 || in1_pc !== sb[0].pc)
            $display("FAIL inst2_only count=%0d pc=%h exp=3/%h", count, in1_pc, sb[0].pc); else passed++;
        step(2'b00, 4'b1001, 1'b0);
        checks++; if (count !== 4'd1 || in1_pc !== third || receive_flag2 !== 1'b0)
            $display("FAIL dual_pop count=%0d pc=%h f2=%b exp=1/%h/0", count, in1_pc, receive_flag2, third); else passed++;
    endtask

    task automatic test_back_to_back();
        step(2'b11, 4'b0000, 1'b0);
        step(2'b11, 4'b0000, 1'b0);
        step(2'b01, 4'b0000, 1'b0);
        checks++; if (count !== 4'd6) $display("FAIL b2b_setup got=%0d exp=6", count); else passed++;
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 4'b1010, 1'b0);
            checks++; if (count !== 4'd6 || in1_pc !== sb[0].pc || in2_pc !== sb[1].pc)
                $display("FAIL b2b_%0d count=%0d pc=%h/%h exp=6/%h/%h", i, count, in1_pc, in2_pc, sb[0].pc, sb[1].pc);
            else passed++;
        end
    endtask

    task automatic test_flush();
        step(2'b11, 4'b1000, 1'b1);
        checks++; if (count !== 4'd0 || receive_flag1 !== 1'b0 || push_ready !== 1'b1)
            $display("FAIL flush count=%0d f1=%b ready=%b exp=0/0/1", count, receive_flag1, push_ready); else passed++;
        step(2'b01, 4'b0000, 1'b0);
        checks++; if (count !== 4'd1 || in1_pc !== sb[0].pc || receive_flag2 !== 1'b0)
            $display("FAIL post_flush count=%0d pc=%h exp=1/%h", count, in1_pc, sb[0].pc); else passed++;
    endtask

`ifdef LAUNCH_QUEUE_PERF_EN
    task automatic test_perf();
        do_reset();
        step(2'b11, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b00, 4'b0000, 1'b0);
        step(2'b00, 4'b1001, 1'b0);
        checks++; if (stall_cnt !== 32'd5 || stall_cnt !== m_stall)
            $display("FAIL perf_stall got=%0d exp=5", stall_cnt); else passed++;
        checks++; if (dual_cnt !== 32'd1 || dual_cnt !== m_dual)
            $display("FAIL perf_dual got=%0d exp=1", dual_cnt); else passed++;
        step(2'b11, 4'b0000, 1'b0);
        step(2'b00, 4'b0000, 1'b1);
        checks++; if (stall_cnt !== m_stall || dual_cnt !== m_dual)
            $display("FAIL perf_hold got=%0d/%0d exp=%0d/%0d", stall_cnt, dual_cnt, m_stall, m_dual); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_push();
        test_full();
        test_inorder();
        test_back_to_back();
        test_flush();
`ifdef LAUNCH_QUEUE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/launch_queue.md
LAUNCH_QUEUE -- requirements
Module: launch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries; power of two, minimum 4.
REQ-002 SHALL have parameter PC_W, default 32, meaning PC and NPC width.
REQ-003 SHALL have parameter DC_W, default 64, meaning decode-output bundle width.
REQ-004 SHALL have port clk, input, 1 bit, meaning single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning reset; synchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit, meaning discard all queued entries.
REQ-007 SHALL have port push_valid, input, 2 bits, meaning decoder slot valids; allowed values are 00, 01 and 11.
REQ-008 SHALL have ports push0_pc/push0_npc/push0_dc, inputs, PC_W/PC_W/DC_W bits, meaning older decoded instruction.
REQ-009 SHALL have ports push1_pc/push1_npc/push1_dc, inputs, PC_W/PC_W/DC_W bits, meaning younger decoded instruction.
REQ-010 SHALL have port push_ready, output, 1 bit, meaning at least 2 free entries.
REQ-011 SHALL have ports in1_pc/in1_npc/in1_decodeout, outputs, PC_W/PC_W/DC_W bits, meaning head entry.
REQ-012 SHALL have port receive_flag1, output, 1 bit, meaning head entry is valid.
REQ-013 SHALL have ports in2_pc/in2_npc/in2_decodeout, outputs, PC_W/PC_W/DC_W bits, meaning head+1 entry.
REQ-014 SHALL have port receive_flag2, output, 1 bit, meaning head+1 entry is valid.
REQ-015 SHALL have port launch_flag, input, 4 bits, meaning launch select result: [3] inst1 to exc1, [2] inst1 to exc2, [1] inst2 to exc1, [0] inst2 to exc2.
REQ-016 SHALL have port count, output, clog2(DEPTH)+1 bits, meaning current occupancy.

Function
REQ-017 SHALL store entries in a circular buffer using head and tail pointers of clog2(DEPTH) bits, with natural wrap from DEPTH-1 to 0.
REQ-018 SHALL assert push_ready when DEPTH-count >= 2, computed from the registered count only; same-cycle pops shall not be credited.
REQ-019 SHALL accept a push only when push_ready=1.
REQ-020 On an accepted push, SHALL write slot0 at tail and slot1 at tail+1 when push_valid=11, then advance tail by popcount(push_valid).
REQ-021 SHALL ignore push_valid when push_ready=0; the upstream stage holds its data.
REQ-022 SHALL drive the in1 outputs combinationally from entry[head], with receive_flag1 = (count>=1).
REQ-023 SHALL drive the in2 outputs from entry[head+1 mod DEPTH], with receive_flag2 = (count>=2).
REQ-024 SHALL compute pop1 = receive_flag1 & (launch_flag[3]|launch_flag[2]).
REQ-025 SHALL compute pop2 = pop1 & receive_flag2 & (launch_flag[1]|launch_flag[0]), so retirement is strictly in order.
REQ-026 SHALL advance head by pop1+pop2 on each edge.
REQ-027 SHALL update count as count + pushed - popped each cycle; simultaneous push and pop shall be legal.
REQ-028 SHALL ignore an inst2 launch without an inst1 launch: no pop, no state change.
REQ-029 On flush=1, SHALL set head, tail and count to 0 at the next edge, overriding any same-cycle push or pop.
REQ-030 SHALL make pushed data visible on in1/in2 one cycle after acceptance (latency 1); no same-cycle bypass.
REQ-031 SHALL leave the contents of invalid entries unspecified; consumers shall qualify them with receive_flag.

Reset
REQ-032 When rst=1 at an edge, SHALL clear head, tail and count to 0; the next cycle receive_flag1=receive_flag2=0 and push_ready=1.
REQ-033 Reset SHALL take priority over flush, push and pop.
REQ-034 SHALL not reset entry storage.

Configuration
REQ-035 When macro LAUNCH_QUEUE_PERF_EN is defined, SHALL add output stall_cnt (32 bits) counting cycles with receive_flag1=1 and pop1=0, plus output dual_cnt (32 bits) counting cycles with pop2=1.
REQ-036 Both counters SHALL wrap at 2^32, clear on rst, and hold on flush.
REQ-037 When LAUNCH_QUEUE_PERF_EN is undefined, SHALL omit these ports and counters entirely.

Verification
REQ-038 Reset then push 11 with PCs 0x100/0x104 -> next cycle receive_flag1=receive_flag2=1, in1_pc=0x100, in2_pc=0x104, count=2.
REQ-039 Fill DEPTH=8 with 4 pushes of 11 -> push_ready=0 when count=7 or 8; a push of 11 while full shall be dropped and count stays 8.
REQ-040 Queue at count=3 with launch_flag=4'b0010 -> no pop, head unchanged; with launch_flag=4'b1001 -> count=1 and in1 shows the former third entry.
REQ-041 Push 11 and pop 2 in the same cycle at count=6 -> count=6 next cycle; head and tail both advance 2 and wrap correctly past index 7.
REQ-042 Assert flush together with push 11 and launch_flag=4'b1000 -> count=0 and receive_flag1=0 next cycle.
REQ-043 With LAUNCH_QUEUE_PERF_EN: 5 cycles of valid head with launch_flag=0, then one dual launch -> stall_cnt=5, dual_cnt=1.
